// File: rtl/layer1_sched.sv
// Sequences one layer of weight-row reads through the shared neuron datapath; results emerge NRN_LAT+3 cycles after start, one per cycle.
// No backpressure: start is ignored while busy, abort cancels the run synchronously.
// Defining LAYER1_SCHED_SATCNT_EN adds a per-run counter of +/-127 results on sat_count.
module layer1_sched #(
    parameter int WIDTH_IN    = 8,
    parameter int NUM_NEURONS = 64,
    parameter int NRN_LAT     = 12,
    parameter int AW          = $clog2(NUM_NEURONS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [4:0]          alpha_cfg,
    output logic                busy,
    output logic                done,
    output logic                act_lock,
    output logic                wmem_rd_en,
    output logic [AW-1:0]       wmem_addr,
    input  logic [783:0]        wmem_rdata,
    output logic [783:0]        nrn_weights,
    output logic [4:0]          nrn_alpha,
    input  logic [WIDTH_IN-1:0] nrn_result,
    output logic                res_valid,
    output logic [AW-1:0]       res_idx,
    output logic [WIDTH_IN-1:0] res_data,
    output logic [AW:0]         sat_count
);

    localparam int DEPTH = NRN_LAT + 2;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       state_q;
    logic                         rd_en_q;
    logic [AW-1:0]                addr_q;
    logic                         done_q;
    logic [4:0]                   alpha_q;
    logic                         rvalid_q;
    logic [783:0]                 weights_q;
    logic [DEPTH-2:0]             tag_vld_q;
    logic [DEPTH-2:0][AW-1:0]     tag_idx_q;
    logic                         res_vld_q;
    logic [AW-1:0]                res_idx_q;
    logic [WIDTH_IN-1:0]          res_data_q;
    logic                         start_acc;
    logic                         kill;

    assign start_acc = (state_q == IDLE) && start && !abort;
    assign kill      = (state_q != IDLE) && abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            alpha_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (kill) begin
                state_q <= IDLE;
                rd_en_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_acc) begin
                            state_q <= RUN;
                            rd_en_q <= 1'b1;
                            addr_q  <= '0;
                            alpha_q <= alpha_cfg;
                        end
                    end
                    RUN: begin
                        if (addr_q == LAST_IDX) begin
                            state_q <= DRAIN;
                            rd_en_q <= 1'b0;
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                    DRAIN: begin
                        if (tag_vld_q == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Stage 0 of the tag pipe is the issue register itself (rd_en_q/addr_q).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_idx_q <= '0;
        end else if (kill) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[DEPTH-3:0], rd_en_q};
            tag_idx_q <= {tag_idx_q[DEPTH-3:0], addr_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q  <= 1'b0;
            weights_q <= '0;
        end else begin
            rvalid_q <= rd_en_q;
            if (rvalid_q) begin
                weights_q <= wmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_vld_q  <= 1'b0;
            res_idx_q  <= '0;
            res_data_q <= '0;
        end else if (kill) begin
            res_vld_q <= 1'b0;
        end else begin
            res_vld_q <= tag_vld_q[DEPTH-2];
            if (tag_vld_q[DEPTH-2]) begin
                res_idx_q  <= tag_idx_q[DEPTH-2];
                res_data_q <= nrn_result;
            end
        end
    end

`ifdef LAYER1_SCHED_SATCNT_EN
    localparam logic [WIDTH_IN-1:0] SAT_POS = WIDTH_IN'(127);
    localparam logic [WIDTH_IN-1:0] SAT_NEG = WIDTH_IN'(-127);

    logic [AW:0] sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else if (start_acc) begin
            sat_q <= '0;
        end else if (res_vld_q && (res_data_q == SAT_POS || res_data_q == SAT_NEG)
                     && sat_q != '1) begin
            sat_q <= sat_q + (AW+1)'(1);
        end
    end

    assign sat_count = sat_q;
`else
    assign sat_count = '0;
`endif

    assign busy        = (state_q != IDLE);
    assign act_lock    = busy;
    assign done        = done_q;
    assign wmem_rd_en  = rd_en_q;
    assign wmem_addr   = addr_q;
    assign nrn_weights = weights_q;
    assign nrn_alpha   = alpha_q;
    assign res_valid   = res_vld_q;
    assign res_idx     = res_idx_q;
    assign res_data    = res_data_q;

endmodule

// File: tb/tb_layer1_sched.sv
// Directed bench for layer1_sched with a registered weight memory and a delay-line neuron model.
module tb_layer1_sched;

    localparam int W   = 8;
    localparam int NN  = 4;
    localparam int LAT = 12;
    localparam int AW  = 2;

`ifdef LAYER1_SCHED_SATCNT_EN
    localparam int EXP_SAT = 2;
`else
    localparam int EXP_SAT = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [4:0]     alpha_cfg = 5'd0;
    logic           busy, done, act_lock, wmem_rd_en;
    logic [AW-1:0]  wmem_addr;
    logic [783:0]   wmem_rdata = '0;
    logic [783:0]   nrn_weights;
    logic [4:0]     nrn_alpha;
    logic [W-1:0]   nrn_result;
    logic           res_valid;
    logic [AW-1:0]  res_idx;
    logic [W-1:0]   res_data;
    logic [AW:0]    sat_count;

    logic [W-1:0]   res_tab [NN] = '{8'h7F, 8'h05, 8'h81, 8'hFD};
    logic [7:0]     dl [LAT-1];

    int n_cmp = 0;
    int n_err = 0;

    layer1_sched #(.WIDTH_IN(W), .NUM_NEURONS(NN), .NRN_LAT(LAT), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .alpha_cfg(alpha_cfg),
        .busy(busy), .done(done), .act_lock(act_lock), .wmem_rd_en(wmem_rd_en),
        .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata), .nrn_weights(nrn_weights),
        .nrn_alpha(nrn_alpha), .nrn_result(nrn_result), .res_valid(res_valid),
        .res_idx(res_idx), .res_data(res_data), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    // Memory returns the row one cycle after the read; the neuron result for a row
    // is presented to the scheduler in the cycle its tag leaves the pipe.
    always @(posedge clk) begin
        if (wmem_rd_en) wmem_rdata <= {8'hA5, 768'b0, 6'b0, wmem_addr};
        dl[0] <= nrn_weights[7:0];
        for (int k = 1; k < LAT-1; k++) dl[k] <= dl[k-1];
    end
    assign nrn_result = res_tab[dl[LAT-2][1:0]];

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, act_lock, wmem_rd_en, res_valid} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, act_lock, wmem_rd_en, res_valid});
        end
        n_cmp++;
        if ({wmem_addr, res_idx, res_data, nrn_alpha, sat_count} !== '0 || nrn_weights !== '0) begin
            n_err++; $display("FAIL reset_data got addr=%0d idx=%0d data=%h alpha=%0d sat=%0d want all 0",
                              wmem_addr, res_idx, res_data, nrn_alpha, sat_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_run(input string name, input int restart_cyc, input logic [4:0] alpha);
        @(negedge clk);
        alpha_cfg = alpha;
        start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            logic exp_v;
            @(negedge clk);
            exp_v = (c >= 15 && c <= 18);
            n_cmp++;
            if (res_valid !== exp_v) begin
                n_err++; $display("FAIL %s res_valid c=%0d got %b want %b", name, c, res_valid, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (res_idx !== AW'(c-15) || res_data !== res_tab[c-15]) begin
                    n_err++; $display("FAIL %s result c=%0d got idx=%0d data=%h want idx=%0d data=%h",
                                      name, c, res_idx, res_data, c-15, res_tab[c-15]);
                end
            end
            n_cmp++;
            if (done !== (c == 19)) begin
                n_err++; $display("FAIL %s done c=%0d got %b want %b", name, c, done, c == 19);
            end
            n_cmp++;
            if (busy !== (c <= 19) || act_lock !== (c <= 19)) begin
                n_err++; $display("FAIL %s busy c=%0d got %b/%b want %b", name, c, busy, act_lock, c <= 19);
            end
            n_cmp++;
            if (wmem_rd_en !== (c <= NN) || (c <= NN && wmem_addr !== AW'(c-1))) begin
                n_err++; $display("FAIL %s rd c=%0d got en=%b addr=%0d want en=%b addr=%0d",
                                  name, c, wmem_rd_en, wmem_addr, c <= NN, c-1);
            end
            if (c == 10) begin
                n_cmp++;
                if (nrn_alpha !== alpha) begin
                    n_err++; $display("FAIL %s alpha got %0d want %0d", name, nrn_alpha, alpha);
                end
            end
            if (c == 20) begin
                n_cmp++;
                if (sat_count !== (AW+1)'(EXP_SAT)) begin
                    n_err++; $display("FAIL %s sat_count got %0d want %0d", name, sat_count, EXP_SAT);
                end
            end
            if (c == 1) start = 1'b0;
            if (c == 3) alpha_cfg = ~alpha;
            if (c == restart_cyc) start = 1'b1;
            if (c == restart_cyc + 1) start = 1'b0;
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 10) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++; $display("FAIL abort_pre busy got %b want 1", busy);
                end
            end
            if (c >= 11) begin
                n_cmp++;
                if ({busy, done, res_valid, wmem_rd_en} !== 4'b0) begin
                    n_err++; $display("FAIL abort c=%0d got busy/done/vld/rd=%b want 0000",
                                      c, {busy, done, res_valid, wmem_rd_en});
                end
            end
            if (c == 1) start = 1'b0;
            if (c == 10) abort = 1'b1;
            if (c == 11) abort = 1'b0;
        end
    endtask

    task automatic test_abort_start();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            n_cmp++;
            if (busy !== 1'b0 || wmem_rd_en !== 1'b0) begin
                n_err++; $display("FAIL abort_start c=%0d got busy=%b rd=%b want 0 0", c, busy, wmem_rd_en);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 9) begin
                n_cmp++;
                if ({busy, done, act_lock, wmem_rd_en, res_valid} !== 5'b0 ||
                    {wmem_addr, res_idx, res_data, nrn_alpha, sat_count} !== '0 || nrn_weights !== '0) begin
                    n_err++; $display("FAIL reset_mid c=9 got busy=%b rd=%b addr=%0d data=%h alpha=%0d w=%h want all 0",
                                      busy, wmem_rd_en, wmem_addr, res_data, nrn_alpha, nrn_weights[7:0]);
                end
            end
            if (c >= 10) begin
                n_cmp++;
                if ({busy, done, res_valid} !== 3'b0) begin
                    n_err++; $display("FAIL reset_mid c=%0d got busy/done/vld=%b want 000", c, {busy, done, res_valid});
                end
            end
            if (c == 1) start = 1'b0;
            if (c == 8) rst_n = 1'b0;
            if (c == 10) rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_run("nominal", -1, 5'd9);
        test_run("start_busy", 5, 5'd17);
        test_abort();
        test_run("after_abort", -1, 5'd3);
        test_abort_start();
        test_reset_mid();
        test_run("after_reset", -1, 5'd30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/layer1_sched.md
LAYER1_SCHED -- requirements
Module: layer1_sched

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  WIDTH_IN, 8, activation/result width; NUM_NEURONS, 64, neurons per layer (>=2); NRN_LAT, 12, neuron datapath latency in cycles from weights stable to result registered; AW, $clog2(NUM_NEURONS), index width.
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous, active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  start  in  1  start-of-layer request, one-cycle pulse
  abort  in  1  synchronous cancel of the current run
  alpha_cfg  in  5  shift value for this run
  busy  out  1  run in progress
  done  out  1  one-cycle pulse, run completed
  act_lock  out  1  activations must be held stable (equals busy)
  wmem_rd_en  out  1  weight memory read enable
  wmem_addr  out  AW  weight row index
  wmem_rdata  in  784  weight row, valid 1 cycle after read
  nrn_weights  out  784  weights to the shared neuron datapath
  nrn_alpha  out  5  alpha to the neuron datapath
  nrn_result  in  WIDTH_IN  signed neuron output
  res_valid  out  1  result strobe
  res_idx  out  AW  neuron index of res_data
  res_data  out  WIDTH_IN  signed result
  sat_count  out  AW+1  saturated results this run

Function
REQ-004 FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-005 IDLE: start=1 -> RUN; rd_idx<=0; nrn_alpha<=alpha_cfg; alpha held constant until the next accepted start.
REQ-006 RUN: wmem_rd_en=1 and wmem_addr=rd_idx each cycle; rd_idx increments; after issuing index NUM_NEURONS-1 -> DRAIN.
REQ-007 nrn_weights SHALL register wmem_rdata the edge after it is valid; it holds its value when no read data is arriving.
REQ-008 A tag pipeline (valid bit + index), depth NRN_LAT+2, SHALL track each issued index; nrn_result is registered into res_data with res_valid=1 and res_idx=tag when the tag exits.
REQ-009 If start is sampled in cycle C0, res_valid for index i SHALL be asserted in cycle C0+NRN_LAT+3+i; results are strictly in index order with no gaps.
REQ-010 DRAIN: -> DONE when the tag pipeline holds no valid entries; DONE asserts done for one cycle, then -> IDLE.
REQ-011 busy=1 in RUN, DRAIN, and DONE; busy deasserts in the cycle after done.
REQ-012 start while busy=1 SHALL be ignored; no queueing.
REQ-013 abort=1 in any non-IDLE state SHALL go to IDLE next edge, clear all tags, suppress further res_valid, and emit no done.
REQ-014 abort and start in the same IDLE cycle: abort wins and start is dropped.
REQ-015 wmem_rd_en SHALL be 0 outside RUN; wmem_addr holds its last value.

Reset
REQ-016 rst_n=0 SHALL force IDLE; busy, done, res_valid, wmem_rd_en, and tags are 0; wmem_addr, res_idx, res_data, nrn_weights, nrn_alpha, and sat_count are 0.
REQ-017 Reset mid-run SHALL discard the run; no done pulse follows deassertion.

Configuration
REQ-018 With LAYER1_SCHED_SATCNT_EN defined, sat_count SHALL clear on an accepted start and increment for each res_valid where res_data equals +127 or -127, saturating at its maximum value.
REQ-019 Without LAYER1_SCHED_SATCNT_EN, sat_count SHALL be constant 0 and no counter logic is present.

Verification
REQ-020 NUM_NEURONS=4, NRN_LAT=12, start at cycle 0 -> res_valid in cycles 15..18 with idx 0..3; done in cycle 19; busy low in cycle 20.
REQ-021 start pulsed again at cycle 5 of a run -> ignored; exactly 4 results and 1 done.
REQ-022 abort in cycle 10 -> no res_valid after cycle 10, no done, busy=0 in cycle 11; a new start afterwards completes normally.
REQ-023 rst_n low in cycle 8 for 2 cycles -> all outputs 0 and no done afterwards; restart produces the correct results.
REQ-024 Model drives nrn_result = +127, 5, -127, -3 (macro on) -> sat_count=2 after done; with the macro off, sat_count=0.
REQ-025 alpha_cfg changed mid-run -> nrn_alpha keeps the value captured at start.
